mips_perf_cnt_bank: RTL and testbench
=====================================

MIPS_PERF_CNT_BANK -- requirements
Module: mips_perf_cnt_bank

Interface
REQ-001 SHALL have parameter NUM_CNT, default 16, number of counters (legal range 1..32).
REQ-002 SHALL have parameter CNT_W, default 32, counter width (legal range 2..32).
REQ-003 SHALL have parameter SATURATE, default 0: 0 = wrap on overflow, 1 = hold at max.
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 SHALL have port mips_cpu_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port mips_cpu_reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port perf_evt, input, NUM_CNT bits: bit i high = one event for counter i in this cycle.
REQ-008 SHALL have port perf_cnt_flag, output, NUM_CNT bits: bit i = counter i nonzero.
REQ-009 SHALL have port perf_cnt_ovf, output, NUM_CNT bits: sticky overflow bit of counter i.
REQ-010 SHALL have AXI-Lite slave ports s_araddr[11:0], s_arvalid, s_arready, s_rdata[31:0], s_rresp[1:0], s_rvalid, s_rready, s_awaddr[11:0], s_awvalid, s_awready, s_wdata[31:0], s_wstrb[3:0], s_wvalid, s_wready, s_bresp[1:0], s_bvalid, s_bready, with standard AXI-Lite directions.

Function
REQ-011 SHALL use this register map: 0x000+4i = live counter i (RO); 0x100+4i = snapshot i (RO); 0x200 = CTRL (write bit0=1 triggers snapshot; reads 0); 0x204 = ENABLE mask (RW); 0x208 = CLEAR (W1 per bit, reads 0); 0x20C = OVF (R, W1C).
REQ-012 SHALL zero-extend counter values to 32 bits on read, return 0 for unmapped reads, and ignore unmapped writes; rresp and bresp SHALL always be 2'b00.
REQ-013 SHALL increment counter i by 1 in a cycle where perf_evt[i]=1 and ENABLE[i]=1; a disabled counter SHALL hold its value.
REQ-014 With SATURATE=0, an increment at 2^CNT_W-1 SHALL wrap the counter to 0 and set OVF[i].
REQ-015 With SATURATE=1, an increment at 2^CNT_W-1 SHALL hold the counter at max and set OVF[i].
REQ-016 A CLEAR write with bit i=1 SHALL zero counter i and OVF[i] at the edge that ends the write-accept cycle.
REQ-017 If a clear and an event for counter i coincide, the clear SHALL win and the counter SHALL become 0.
REQ-018 A snapshot SHALL copy all counters' pre-increment values in the acceptance cycle into the snapshot registers; coincident events SHALL still increment the live counters.
REQ-019 If an OVF W1C write and a new overflow of the same counter coincide, the set SHALL win.
REQ-020 Read channel: s_arready SHALL be 1 whenever s_rvalid=0; on s_arvalid&&s_arready, s_rvalid SHALL rise the next cycle, carrying data sampled in the acceptance cycle.
REQ-021 s_rvalid and s_rdata SHALL hold stable until s_rvalid&&s_rready, then s_rvalid SHALL drop.
REQ-022 Write channel: s_awready and s_wready SHALL be asserted together only in a cycle where s_awvalid=1, s_wvalid=1 and s_bvalid=0.
REQ-023 The write effect SHALL apply at the edge ending the acceptance cycle; s_bvalid SHALL rise the next cycle and hold until s_bready.
REQ-024 s_wstrb SHALL be ignored; every write SHALL be treated as a full 32-bit word.
REQ-025 perf_cnt_flag and perf_cnt_ovf SHALL be combinational decodes of the registered state, with no added latency.

Reset
REQ-026 On mips_cpu_reset=1 at a clock edge: all counters, snapshots and OVF SHALL be 0; ENABLE SHALL be all ones; s_rvalid and s_bvalid SHALL be 0.
REQ-027 A reset during a pending read or write SHALL abort it; no response SHALL be issued after reset.
REQ-028 Reset SHALL take priority over events, clears and snapshots in the same cycle.

Verification
REQ-029 Reset, then perf_evt[0]=1 for 5 cycles -> read 0x000 returns 5, perf_cnt_flag[0]=1, other flags 0.
REQ-030 CNT_W=4, SATURATE=0, 17 events on counter 1 -> counter=1, perf_cnt_ovf[1]=1; write 0x20C=0x2 -> OVF reads 0.
REQ-031 CNT_W=4, SATURATE=1, 20 events -> counter=15, OVF=1.
REQ-032 Counter 2 at 7 with continuous events; write CTRL=1 -> snapshot 0x108 = 7; live counter keeps incrementing.
REQ-033 Write CLEAR=0x1 in the same cycle as perf_evt[0]=1 -> counter 0 reads 0; write ENABLE=0 plus events -> counters unchanged.
REQ-034 Hold s_rready=0 for 3 cycles after a read -> s_rvalid and s_rdata stay stable and s_arready=0 throughout.

Source files
------------

// File: rtl/mips_perf_cnt_bank.sv
// Bank of event counters with snapshot, clear and sticky overflow,
// read and written over an AXI-Lite slave (live, snapshot, CTRL/ENABLE/CLEAR/OVF).
// Ports: mips_cpu_clk, mips_cpu_reset (sync, active-high),
//        perf_evt in, perf_cnt_flag/perf_cnt_ovf out, s_* AXI-Lite slave.
module mips_perf_cnt_bank #(
  parameter int NUM_CNT  = 16,
  parameter int CNT_W    = 32,
  parameter bit SATURATE = 1'b0
) (
  input  logic               mips_cpu_clk,
  input  logic               mips_cpu_reset,
  input  logic [NUM_CNT-1:0] perf_evt,
  output logic [NUM_CNT-1:0] perf_cnt_flag,
  output logic [NUM_CNT-1:0] perf_cnt_ovf,
  input  logic [11:0]        s_araddr,
  input  logic               s_arvalid,
  output logic               s_arready,
  output logic [31:0]        s_rdata,
  output logic [1:0]         s_rresp,
  output logic               s_rvalid,
  input  logic               s_rready,
  input  logic [11:0]        s_awaddr,
  input  logic               s_awvalid,
  output logic               s_awready,
  input  logic [31:0]        s_wdata,
  input  logic [3:0]         s_wstrb,
  input  logic               s_wvalid,
  output logic               s_wready,
  output logic [1:0]         s_bresp,
  output logic               s_bvalid,
  input  logic               s_bready
);

  localparam logic [CNT_W-1:0] MAX = '1;
  localparam logic [CNT_W-1:0] ONE =
    {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] TOP =
    SATURATE ? MAX : '0;

  logic [CNT_W-1:0]   cnt  [NUM_CNT];
  logic [CNT_W-1:0]   snap [NUM_CNT];
  logic [NUM_CNT-1:0] ovf;
  logic [NUM_CNT-1:0] en;
  logic               rvalid_q;
  logic               bvalid_q;
  logic [31:0]        rdata_q;

  logic               rd_acc;
  logic               wr_acc;
  logic [9:0]         wa;
  logic [9:0]         ra;
  logic               wr_ctrl;
  logic               wr_en;
  logic               wr_clr;
  logic               wr_ovf;
  logic               snap_go;
  logic [NUM_CNT-1:0] clr;
  logic [NUM_CNT-1:0] w1c;
  logic [NUM_CNT-1:0] inc;
  logic [31:0]        live_v;
  logic [31:0]        snap_v;
  logic [31:0]        rd_val;
  logic               unused;

  assign unused = ^{s_wstrb, s_araddr[1:0],
                    s_awaddr[1:0], s_wdata};

  assign s_arready = !rvalid_q;
  assign rd_acc    = s_arvalid && !rvalid_q;
  assign wr_acc    = s_awvalid && s_wvalid
                     && !bvalid_q;
  assign s_awready = wr_acc;
  assign s_wready  = wr_acc;
  assign s_rvalid  = rvalid_q;
  assign s_rdata   = rdata_q;
  assign s_bvalid  = bvalid_q;
  assign s_rresp   = 2'b00;
  assign s_bresp   = 2'b00;

  assign wa      = s_awaddr[11:2];
  assign ra      = s_araddr[11:2];
  assign wr_ctrl = wr_acc && (wa == 10'h080);
  assign wr_en   = wr_acc && (wa == 10'h081);
  assign wr_clr  = wr_acc && (wa == 10'h082);
  assign wr_ovf  = wr_acc && (wa == 10'h083);
  assign snap_go = wr_ctrl && s_wdata[0];
  assign clr = wr_clr ? s_wdata[NUM_CNT-1:0] : '0;
  assign w1c = wr_ovf ? s_wdata[NUM_CNT-1:0] : '0;
  assign inc = perf_evt & en;

  // Index beyond NUM_CNT leaves the value at 0.
  always_comb begin
    live_v = '0;
    snap_v = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (ra[5:0] == 6'(i)) begin
        live_v = 32'(cnt[i]);
        snap_v = 32'(snap[i]);
      end
    end
  end

  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      (ra[9:6] == 4'h0): rd_val = live_v;
      (ra[9:6] == 4'h1): rd_val = snap_v;
      (ra == 10'h081):   rd_val = 32'(en);
      (ra == 10'h083):   rd_val = 32'(ovf);
      default:           rd_val = '0;
    endcase
  end

  always_comb begin
    perf_cnt_flag = '0;
    for (int i = 0; i < NUM_CNT; i++)
      perf_cnt_flag[i] = |cnt[i];
  end

  assign perf_cnt_ovf = ovf;

  always_ff @(posedge mips_cpu_clk) begin
    if (mips_cpu_reset) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        cnt[i]  <= '0;
        snap[i] <= '0;
      end
      ovf      <= '0;
      en       <= '1;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      bvalid_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CNT; i++) begin
        // Snapshot takes the pre-increment value.
        if (snap_go)
          snap[i] <= cnt[i];
        if (clr[i]) begin
          cnt[i] <= '0;
          ovf[i] <= 1'b0;
        end else begin
          if (inc[i])
            cnt[i] <= (cnt[i] == MAX) ? TOP
                                      : cnt[i] + ONE;
          // A new overflow beats a W1C.
          if (inc[i] && (cnt[i] == MAX))
            ovf[i] <= 1'b1;
          else if (w1c[i])
            ovf[i] <= 1'b0;
        end
      end
      if (wr_en)
        en <= s_wdata[NUM_CNT-1:0];
      if (rd_acc) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_val;
      end else if (rvalid_q && s_rready) begin
        rvalid_q <= 1'b0;
      end
      if (wr_acc)
        bvalid_q <= 1'b1;
      else if (bvalid_q && s_bready)
        bvalid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_perf_cnt_bank.sv
// Directed bench for mips_perf_cnt_bank: default, 4-bit wrap and
// 4-bit saturating instances share one stimulus stream.
module tb_mips_perf_cnt_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] evt;
  logic [11:0] araddr;
  logic        arvalid;
  logic        rready;
  logic [11:0] awaddr;
  logic        awvalid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        bready;

  logic [15:0] flag_a, ovf_a;
  logic [3:0]  flag_b, ovf_b, flag_c, ovf_c;
  logic        arready_a, arready_b, arready_c;
  logic        rvalid_a, rvalid_b, rvalid_c;
  logic [31:0] rdata_a, rdata_b, rdata_c;
  logic [1:0]  rresp_a, rresp_b, rresp_c;
  logic        awready_a, awready_b, awready_c;
  logic        wready_a, wready_b, wready_c;
  logic        bvalid_a, bvalid_b, bvalid_c;
  logic [1:0]  bresp_a, bresp_b, bresp_c;

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  mips_perf_cnt_bank #(
    .NUM_CNT(16), .CNT_W(32), .SATURATE(1'b0)
  ) u_a (
    .mips_cpu_clk(clk), .mips_cpu_reset(rst),
    .perf_evt(evt),
    .perf_cnt_flag(flag_a), .perf_cnt_ovf(ovf_a),
    .s_araddr(araddr), .s_arvalid(arvalid),
    .s_arready(arready_a), .s_rdata(rdata_a),
    .s_rresp(rresp_a), .s_rvalid(rvalid_a),
    .s_rready(rready), .s_awaddr(awaddr),
    .s_awvalid(awvalid), .s_awready(awready_a),
    .s_wdata(wdata), .s_wstrb(wstrb),
    .s_wvalid(wvalid), .s_wready(wready_a),
    .s_bresp(bresp_a), .s_bvalid(bvalid_a),
    .s_bready(bready)
  );

  mips_perf_cnt_bank #(
    .NUM_CNT(4), .CNT_W(4), .SATURATE(1'b0)
  ) u_b (
    .mips_cpu_clk(clk), .mips_cpu_reset(rst),
    .perf_evt(evt[3:0]),
    .perf_cnt_flag(flag_b), .perf_cnt_ovf(ovf_b),
    .s_araddr(araddr), .s_arvalid(arvalid),
    .s_arready(arready_b), .s_rdata(rdata_b),
    .s_rresp(rresp_b), .s_rvalid(rvalid_b),
    .s_rready(rready), .s_awaddr(awaddr),
    .s_awvalid(awvalid), .s_awready(awready_b),
    .s_wdata(wdata), .s_wstrb(wstrb),
    .s_wvalid(wvalid), .s_wready(wready_b),
    .s_bresp(bresp_b), .s_bvalid(bvalid_b),
    .s_bready(bready)
  );

  mips_perf_cnt_bank #(
    .NUM_CNT(4), .CNT_W(4), .SATURATE(1'b1)
  ) u_c (
    .mips_cpu_clk(clk), .mips_cpu_reset(rst),
    .perf_evt(evt[3:0]),
    .perf_cnt_flag(flag_c), .perf_cnt_ovf(ovf_c),
    .s_araddr(araddr), .s_arvalid(arvalid),
    .s_arready(arready_c), .s_rdata(rdata_c),
    .s_rresp(rresp_c), .s_rvalid(rvalid_c),
    .s_rready(rready), .s_awaddr(awaddr),
    .s_awvalid(awvalid), .s_awready(awready_c),
    .s_wdata(wdata), .s_wstrb(wstrb),
    .s_wvalid(wvalid), .s_wready(wready_c),
    .s_bresp(bresp_c), .s_bvalid(bvalid_c),
    .s_bready(bready)
  );

  typedef struct {
    logic [15:0] evt;
    int          cyc;
    logic [11:0] addr;
    logic [31:0] ea;
    logic [31:0] eb;
    logic [31:0] ec;
  } vec_t;

  vec_t tv[9];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s got %h want %h",
               nm, act, exp);
    end
  endtask

  // Entered and left 1 time unit after a rising edge.
  task automatic do_read(input logic [11:0] a,
                         output logic [31:0] da,
                         output logic [31:0] db,
                         output logic [31:0] dc);
    araddr  = a;
    arvalid = 1'b1;
    rready  = 1'b1;
    chk("arready", 32'(arready_a), 32'd1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    chk("rvalid", 32'(rvalid_a), 32'd1);
    da = rdata_a;
    db = rdata_b;
    dc = rdata_c;
    @(posedge clk); #1;
  endtask

  task automatic do_write(input logic [11:0] a,
                          input logic [31:0] d,
                          input logic [15:0] e);
    awaddr  = a;
    wdata   = d;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    bready  = 1'b1;
    evt     = e;
    @(posedge clk); #1;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    evt     = '0;
    chk("bvalid", 32'(bvalid_a), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic rd3(input string nm,
                     input logic [11:0] a,
                     input logic [31:0] ea,
                     input logic [31:0] eb,
                     input logic [31:0] ec);
    logic [31:0] da, db, dc;
    do_read(a, da, db, dc);
    chk({nm, "_a"}, da, ea);
    chk({nm, "_b"}, db, eb);
    chk({nm, "_c"}, dc, ec);
  endtask

  initial begin
    rst = 1'b1; evt = '0;
    araddr = '0; arvalid = 1'b0; rready = 1'b1;
    awaddr = '0; awvalid = 1'b0; wdata = '0;
    wstrb = 4'hF; wvalid = 1'b0; bready = 1'b1;

    tv[0] = '{16'h0001, 5,  12'h000, 5,  5, 5};
    tv[1] = '{16'h0002, 17, 12'h004, 17, 1, 15};
    tv[2] = '{16'h0000, 0,  12'h20C, 0,  2, 2};
    tv[3] = '{16'h0002, 3,  12'h004, 20, 4, 15};
    tv[4] = '{16'h0008, 2,  12'h00C, 2,  2, 2};
    tv[5] = '{16'h0000, 0,  12'h3F0, 0,  0, 0};
    tv[6] = '{16'h0000, 0,  12'h010, 0,  0, 0};
    tv[7] = '{16'h0100, 4,  12'h020, 4,  0, 0};
    tv[8] = '{16'h0000, 0,  12'h208, 0,  0, 0};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_flag_a", 32'(flag_a), 0);
    chk("rst_ovf_a", 32'(ovf_a), 0);
    chk("rst_rvalid", 32'(rvalid_a), 0);
    chk("rst_bvalid", 32'(bvalid_a), 0);
    rd3("rst_en", 12'h204, 32'hFFFF, 32'hF, 32'hF);
    rd3("rst_cnt0", 12'h000, 0, 0, 0);

    for (int k = 0; k < 9; k++) begin
      evt = tv[k].evt;
      repeat (tv[k].cyc) @(posedge clk);
      #1 evt = '0;
      rd3($sformatf("vec%0d", k), tv[k].addr,
          tv[k].ea, tv[k].eb, tv[k].ec);
      if (k == 0) begin
        chk("flag_a0", 32'(flag_a), 32'h1);
        chk("flag_b0", 32'(flag_b), 32'h1);
      end
      if (k == 1) begin
        chk("ovf_a1", 32'(ovf_a), 0);
        chk("ovf_b1", 32'(ovf_b), 32'h2);
        chk("ovf_c1", 32'(ovf_c), 32'h2);
      end
    end
    chk("resp", 32'({rresp_a, bresp_b}), 0);

    // OVF write-one-to-clear
    do_write(12'h20C, 32'h2, 16'h0);
    rd3("ovf_w1c", 12'h20C, 0, 0, 0);
    chk("ovf_out_b", 32'(ovf_b), 0);

    // Read response held while rready is low
    araddr = 12'h004; arvalid = 1'b1; rready = 1'b0;
    @(posedge clk); #1;
    arvalid = 1'b0;
    for (int j = 0; j < 3; j++) begin
      chk("hold_rvalid", 32'(rvalid_a), 1);
      chk("hold_rdata", rdata_a, 32'd20);
      chk("hold_arready", 32'(arready_a), 0);
      @(posedge clk); #1;
    end
    rready = 1'b1;
    @(posedge clk); #1;
    chk("hold_drop", 32'(rvalid_a), 0);
    chk("hold_arrdy", 32'(arready_a), 1);

    // Snapshot with events running on counter 2
    evt = 16'h0004;
    repeat (7) @(posedge clk);
    #1;
    do_write(12'h200, 32'h1, 16'h0004);
    rd3("snap2", 12'h108, 7, 7, 7);
    rd3("live2", 12'h008, 8, 8, 8);
    rd3("snap1", 12'h104, 20, 4, 15);
    rd3("ctrl_rd", 12'h200, 0, 0, 0);

    // Clear coinciding with an event
    do_write(12'h208, 32'h1, 16'h0001);
    rd3("clr0", 12'h000, 0, 0, 0);
    chk("clr_flag_a", 32'(flag_a[0]), 0);

    // Disabled counters hold
    do_write(12'h204, 32'h0, 16'h0);
    evt = 16'hFFFF;
    repeat (3) @(posedge clk);
    #1 evt = '0;
    rd3("dis1", 12'h004, 20, 4, 15);
    rd3("dis2", 12'h008, 8, 8, 8);
    rd3("en_rd", 12'h204, 0, 0, 0);
    do_write(12'h204, 32'hFFFF, 16'h0);

    // Reset aborts a pending write response
    awaddr = 12'h204; wdata = 32'h0;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    chk("pend_bvalid", 32'(bvalid_a), 1);
    rst = 1'b1; evt = 16'hFFFF;
    @(posedge clk); #1;
    rst = 1'b0; evt = '0;
    chk("abort_b_a", 32'(bvalid_a), 0);
    chk("abort_b_c", 32'(bvalid_c), 0);
    chk("rst2_flag_a", 32'(flag_a), 0);
    chk("rst2_flag_c", 32'(flag_c), 0);
    bready = 1'b1;
    @(posedge clk); #1;
    chk("no_resp", 32'(bvalid_a), 0);
    rd3("rst2_en", 12'h204, 32'hFFFF, 32'hF, 32'hF);
    rd3("rst2_snap", 12'h108, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed",
             ntests, nfail);
    $finish;
  end

endmodule
